// File: rtl/sbox_lane_pipe.sv
// Elastic, mode-switchable AES S-box array: NUM_LANES independent byte lanes per transfer.
// Forward/inverse S-box is computed as GF(2^8) inversion combined with the affine map.
module sbox_lane_pipe #(
    parameter int unsigned NUM_LANES   = 4,
    parameter int unsigned PIPE_STAGES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_mode,
    input  logic [8*NUM_LANES-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_mode,
    output logic [8*NUM_LANES-1:0] out_data,
    output logic [1:0]             occupancy
);
    localparam int unsigned W = 8 * NUM_LANES;

    // Multiplication modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse, and maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]}
               ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] b);
        logic [7:0] v;
        v = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return gf_inv(v);
    endfunction

    function automatic logic [W-1:0] sub_word(input logic [W-1:0] d, input logic inv);
        logic [W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            r[8*i +: 8] = inv ? sbox_inv(d[8*i +: 8]) : sbox_fwd(d[8*i +: 8]);
        end
        return r;
    endfunction

    logic         s1_valid;
    logic         s1_mode;
    logic [W-1:0] s1_data;
    logic [W-1:0] s1_load;
    logic         ready1;

    assign in_ready = ready1 && !flush && !rst;

    // Inside the ready1 branch in_ready is true, so in_valid alone marks a transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s1_data  <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (ready1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mode <= in_mode;
                s1_data <= s1_load;
            end
        end
    end

    if (PIPE_STAGES == 1) begin : g_one_stage
        assign s1_load   = sub_word(in_data, in_mode);
        assign ready1    = !s1_valid || out_ready;
        assign out_valid = s1_valid && !flush;
        assign out_mode  = s1_mode;
        assign out_data  = s1_data;
        assign occupancy = {1'b0, s1_valid};
    end else begin : g_two_stage
        logic         s2_valid;
        logic         s2_mode;
        logic [W-1:0] s2_data;
        logic         ready2;

        assign s1_load = in_data;
        assign ready2  = !s2_valid || out_ready;
        assign ready1  = !s1_valid || ready2;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s2_valid <= 1'b0;
                s2_mode  <= 1'b0;
                s2_data  <= '0;
            end else if (flush) begin
                s2_valid <= 1'b0;
            end else if (ready2) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_mode <= s1_mode;
                    s2_data <= sub_word(s1_data, s1_mode);
                end
            end
        end

        assign out_valid = s2_valid && !flush;
        assign out_mode  = s2_mode;
        assign out_data  = s2_data;
        assign occupancy = {1'b0, s1_valid} + {1'b0, s2_valid};
    end
endmodule
